fifo_ctrl_param: RTL and testbench
==================================

# fifo_ctrl_param

Parametrised pointer and flag controller for the synchronous FIFO. Generates write/read addresses for the FIFO storage array, gates incoming write/read requests against full/empty, and reports occupancy, almost-full/almost-empty, and sticky overflow/underflow errors. Sits between the producer/consumer request lines and the dual-port storage RAM. It supersedes the fixed 8-entry controller with a depth set by `ADDR_W`.

## Interface
- `ADDR_W`, default 3: address width; depth `DEPTH = 2**ADDR_W`, derived locally and not overridable.
- `AF_LEVEL`, default `DEPTH-2`: `almost_full` asserts when `count >= AF_LEVEL`.
- `AE_LEVEL`, default 1: `almost_empty` asserts when `count <= AE_LEVEL`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `clr`  in  1  synchronous flush.
- `write_signal`  in  1  producer write request.
- `read_signal`  in  1  consumer read request.
- `write_addr`  out  ADDR_W  RAM write address for the current cycle.
- `read_addr`  out  ADDR_W  RAM read address for the current cycle.
- `write_en`  out  1  write accepted this cycle; drives RAM write enable.
- `read_en`  out  1  read accepted this cycle.
- `full`, `empty`  out  1  occupancy flags.
- `count`  out  ADDR_W+1  occupancy, 0..DEPTH.
- `almost_full`, `almost_empty`  out  1  threshold flags.
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- Internal write and read pointers are ADDR_W+1 bits wide; the top bit is the wrap bit.
- `write_addr` and `read_addr` are the low ADDR_W bits of the pointers. They wrap from DEPTH-1 to 0.
- `empty` = pointers equal. `full` = low bits equal and wrap bits differ. `count` = wptr − rptr, modulo 2**(ADDR_W+1).
- `read_en` = `read_signal & !empty`.
- `write_en` = `write_signal & (!full | read_signal)`. A read is always accepted when full, so a simultaneous read/write at full is accepted for both; count is unchanged and both addresses advance.
- Simultaneous read/write at empty: only the write is accepted, with no fall-through; count becomes 1.
- `overflow` sets on `write_signal & full & !read_signal`.
- `underflow` sets on `read_signal & empty`.
- Rejected requests do not move the pointers.
- Priority is `rst` > `clr` > normal operation.
- `clr` zeroes the pointers and both sticky flags. While `clr` is high, `write_en` and `read_en` are 0 and requests are dropped without setting error flags.
- `count` width rule: ADDR_W+1 bits, so that DEPTH is representable.

## Timing
- All state changes on the rising edge of `clk`.
- `full`, `empty`, `count` and the almost flags decode from registered pointers only; there is no combinational path from the request inputs to them.
- `write_en` and `read_en` are combinational from the requests and the registered flags, valid in the same cycle.
- An address advances at the edge that ends the accepting cycle.
- A write accepted in cycle N is readable from cycle N+1, when `empty` is already low.
- Reset values: pointers 0, `write_addr` 0, `read_addr` 0, `count` 0, `empty` 1, `full` 0, `almost_empty` 1 (0 with the macro off), `almost_full` 0, `overflow` 0, `underflow` 0.
- Asserting `rst` or `clr` mid-burst takes effect at the next edge regardless of pending requests.

## Configuration
- Macro: `FIFO_CTRL_ALMOST_FLAGS_EN`.
- Defined: `almost_full` and `almost_empty` are decoded from `count` against `AF_LEVEL` and `AE_LEVEL`.
- Undefined: the threshold comparators are not built; `almost_full` and `almost_empty` are tied to 0, and the ports remain for interface stability.

## Structure
- Shared package `fifo_pkg` holds the default `ADDR_W` constant, a pointer-width helper function (ADDR_W+1), and the error-flag bit-position constants reused by the FIFO top level.
- One sub-module, `fifo_ptr_ctr`: an ADDR_W+1-bit wrap-bit pointer counter with synchronous reset, clear and increment enable, instantiated twice (write and read).

## Test plan
Configuration for all scenarios: ADDR_W=3, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
- Reset: `rst`=1 for 2 cycles with both requests high → addresses 0, `count` 0, `empty`=1, `full`=0, `write_en`=0, `read_en`=0, no error flags set.
- Fill: 8 consecutive writes → `write_addr` steps 0..7 then 0; `full`=1 and `count`=8 after the 8th edge. A 9th write alone → `write_en`=0, `overflow`=1, `write_addr` stays 0.
- Drain: from full, 8 reads → `read_addr` steps 0..7 then 0; `empty`=1 after the 8th edge. A 9th read → `read_en`=0, `underflow`=1.
- Simultaneous requests: at full, read+write → both enables 1, `count` stays 8, `overflow` stays 0. At empty, read+write → `write_en`=1, `read_en`=0, `count`=1, `underflow`=1.
- Wrap and thresholds: 5 writes, 5 reads, 6 writes → `write_addr`=3, `read_addr`=5, `count`=6, `almost_full`=1 (0 with the macro undefined). Then 5 reads → `count`=1, `almost_empty`=1.
- Flush: at `count`=5 with `overflow`=1, pulse `clr` with `write_signal`=1 → next cycle `count`=0, `empty`=1, `overflow`=0, both addresses 0, `write_en`=0 during the pulse.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default address width, pointer-width
// helper and the bit positions of the sticky error flags.
package fifo_pkg;

  localparam int FIFO_ADDR_W_DEFAULT = 3;

  localparam int ERR_W       = 2;
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UDF_BIT = 1;

  // One extra wrap bit lets full and empty be told apart when the low bits match.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrap-bit pointer counter: synchronous reset, synchronous clear, increment enable.
module fifo_ptr_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_r;

  // Pointer register; rolls over naturally at 2**W, toggling the wrap bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {W{1'b0}};
    end else if (clr) begin
      ptr_r <= {W{1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + W'(1);
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl_param.sv
// Parametrised FIFO pointer/flag controller (depth 2**ADDR_W).
// Optional threshold flags are built only when FIFO_CTRL_ALMOST_FLAGS_EN is defined.
module fifo_ctrl_param
  import fifo_pkg::*;
#(
  parameter int ADDR_W   = FIFO_ADDR_W_DEFAULT,
  parameter int AF_LEVEL = (2 ** ADDR_W) - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              write_signal,
  input  logic              read_signal,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ADDR_W-1:0] read_addr,
  output logic              write_en,
  output logic              read_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = ptr_width(ADDR_W);

  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_level_check
    $error("fifo_ctrl_param: almost-flag level outside 0..DEPTH");
  end

  logic [PW-1:0]    wptr_s;
  logic [PW-1:0]    rptr_s;
  logic [PW-1:0]    count_s;
  logic             full_s;
  logic             empty_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic [ERR_W-1:0] err_r;

  fifo_ptr_ctr #(.W(PW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wr_acc_s),
    .ptr (wptr_s)
  );

  fifo_ptr_ctr #(.W(PW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (rd_acc_s),
    .ptr (rptr_s)
  );

  assign empty_s = (wptr_s == rptr_s);
  assign full_s  = (wptr_s[ADDR_W-1:0] == rptr_s[ADDR_W-1:0]) &&
                   (wptr_s[ADDR_W] != rptr_s[ADDR_W]);
  assign count_s = wptr_s - rptr_s;

  // Request gating; a read at full frees the slot the concurrent write lands in.
  always_comb begin
    wr_acc_s = 1'b0;
    rd_acc_s = 1'b0;
    if (!rst && !clr) begin
      rd_acc_s = read_signal & ~empty_s;
      wr_acc_s = write_signal & (~full_s | read_signal);
    end else begin
      rd_acc_s = 1'b0;
      wr_acc_s = 1'b0;
    end
  end

  // Sticky error flags; requests dropped during clr never set them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= {ERR_W{1'b0}};
    end else if (clr) begin
      err_r <= {ERR_W{1'b0}};
    end else begin
      if (write_signal & full_s & ~read_signal) begin
        err_r[ERR_OVF_BIT] <= 1'b1;
      end
      if (read_signal & empty_s) begin
        err_r[ERR_UDF_BIT] <= 1'b1;
      end
    end
  end

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  localparam logic [PW-1:0] AF_LVL_C = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LVL_C = PW'(AE_LEVEL);
  assign almost_full  = (count_s >= AF_LVL_C);
  assign almost_empty = (count_s <= AE_LVL_C);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

  assign write_addr = wptr_s[ADDR_W-1:0];
  assign read_addr  = rptr_s[ADDR_W-1:0];
  assign write_en   = wr_acc_s;
  assign read_en    = rd_acc_s;
  assign full       = full_s;
  assign empty      = empty_s;
  assign count      = count_s;
  assign overflow   = err_r[ERR_OVF_BIT];
  assign underflow  = err_r[ERR_UDF_BIT];

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Self-checking bench for fifo_ctrl_param (ADDR_W=3): directed test-plan
// sequences followed by randomized traffic against an occupancy-level model.
module tb_fifo_ctrl_param;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          write_signal = 1'b0;
  logic          read_signal = 1'b0;
  logic [AW-1:0] write_addr;
  logic [AW-1:0] read_addr;
  logic          write_en;
  logic          read_en;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int failures = 0;

  // Reference model: occupancy and address positions as plain integers.
  int m_cnt = 0;
  int m_wa  = 0;
  int m_ra  = 0;
  int m_ovf = 0;
  int m_udf = 0;

  fifo_ctrl_param #(.ADDR_W(AW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .write_signal (write_signal),
    .read_signal  (read_signal),
    .write_addr   (write_addr),
    .read_addr    (read_addr),
    .write_en     (write_en),
    .read_en      (read_en),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check all outputs, then advance the model at posedge.
  task automatic step(input logic r_rst, input logic r_clr, input logic w, input logic r,
                      input bit do_check);
    int exp_we;
    int exp_re;
    int exp_af;
    int exp_ae;
    @(negedge clk);
    rst = r_rst;
    clr = r_clr;
    write_signal = w;
    read_signal = r;
    #1;
    exp_we = (!r_rst && !r_clr && w && (m_cnt < DEPTH || r)) ? 1 : 0;
    exp_re = (!r_rst && !r_clr && r && m_cnt > 0) ? 1 : 0;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    exp_af = (m_cnt >= AFL) ? 1 : 0;
    exp_ae = (m_cnt <= AEL) ? 1 : 0;
`else
    exp_af = 0;
    exp_ae = 0;
`endif
    if (do_check) begin
      check_val("write_en", int'(write_en), exp_we);
      check_val("read_en", int'(read_en), exp_re);
      check_val("count", int'(count), m_cnt);
      check_val("empty", int'(empty), (m_cnt == 0) ? 1 : 0);
      check_val("full", int'(full), (m_cnt == DEPTH) ? 1 : 0);
      check_val("write_addr", int'(write_addr), m_wa);
      check_val("read_addr", int'(read_addr), m_ra);
      check_val("overflow", int'(overflow), m_ovf);
      check_val("underflow", int'(underflow), m_udf);
      check_val("almost_full", int'(almost_full), exp_af);
      check_val("almost_empty", int'(almost_empty), exp_ae);
    end
    @(posedge clk);
    if (r_rst || r_clr) begin
      m_cnt = 0; m_wa = 0; m_ra = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (w && m_cnt == DEPTH && !r) m_ovf = 1;
      if (r && m_cnt == 0) m_udf = 1;
      m_cnt = m_cnt + exp_we - exp_re;
      m_wa  = (m_wa + exp_we) % DEPTH;
      m_ra  = (m_ra + exp_re) % DEPTH;
    end
  endtask

  task automatic repeat_op(input int n, input logic w, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, w, r, 1'b1);
  endtask

  initial begin
    int wprob;
    // Reset with both requests high; first cycle state is still unknown.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // Fill, overflow, drain, underflow.
    repeat_op(8, 1'b1, 1'b0);
    repeat_op(1, 1'b1, 1'b0);
    repeat_op(8, 1'b0, 1'b1);
    repeat_op(1, 1'b0, 1'b1);
    // Simultaneous requests at full and at empty.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat_op(8, 1'b1, 1'b0);
    repeat_op(1, 1'b1, 1'b1);
    repeat_op(8, 1'b0, 1'b1);
    repeat_op(1, 1'b1, 1'b1);
    // Wrap and thresholds.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat_op(5, 1'b1, 1'b0);
    repeat_op(5, 1'b0, 1'b1);
    repeat_op(6, 1'b1, 1'b0);
    repeat_op(5, 1'b0, 1'b1);
    repeat_op(1, 1'b0, 1'b0);
    // Flush at count 5 with overflow set.
    repeat_op(7, 1'b1, 1'b0);
    repeat_op(1, 1'b1, 1'b0);
    repeat_op(3, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat_op(1, 1'b0, 1'b0);
    // Randomized traffic with phases that push toward full or empty.
    wprob = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 48 == 0) wprob = ($urandom_range(0, 1) == 0) ? 20 : 80;
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < wprob) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < (100 - wprob)) ? 1'b1 : 1'b0,
           1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
